// File: rtl/barrel_shift_sequencer_4_bit_if.sv
// rtl/barrel_shift_sequencer_4_bit_if.sv - command/result handshake bundle for barrel_shift_sequencer_4_bit
interface barrel_shift_sequencer_4_bit_if;
  logic       cmd_tvalid;
  logic       cmd_tready;
  logic [2:0] cmd_mode;
  logic [3:0] cmd_amount;
  logic       cmd_carry;
  logic [3:0] cmd_tdata;
  logic       res_tvalid;
  logic       res_tready;
  logic [3:0] res_tdata;
  logic       res_carry;
  logic       busy;

  modport master (
    output cmd_tvalid, cmd_mode, cmd_amount, cmd_carry, cmd_tdata, res_tready,
    input  cmd_tready, res_tvalid, res_tdata, res_carry, busy
  );

  modport slave (
    input  cmd_tvalid, cmd_mode, cmd_amount, cmd_carry, cmd_tdata, res_tready,
    output cmd_tready, res_tvalid, res_tdata, res_carry, busy
  );
endinterface

// File: rtl/barrel_shift_sequencer_4_bit.sv
// rtl/barrel_shift_sequencer_4_bit.sv - multi-pass shift/rotate sequencer around a 3-bit-per-pass shifter
// Optional macro SHIFT_SEQ_AMOUNT_REDUCE_EN folds the amount at capture to shorten long commands.
module barrel_shifter_4_bit (
  input  logic       enable,
  input  logic [2:0] mode,
  input  logic [1:0] length,
  input  logic [3:0] data_in,
  input  logic       carry_in,
  output logic [3:0] data_out,
  output logic       carry_out
);
  logic [4:0] cd;
  logic [4:0] cd_rot;

  assign cd = {carry_in, data_in};

  always_comb begin
    data_out  = data_in;
    carry_out = carry_in;
    cd_rot    = cd;
    if (enable) begin
      case (mode)
        3'd0, 3'd2: data_out = data_in << length;
        3'd1:       data_out = data_in >> length;
        3'd3:       data_out = $signed(data_in) >>> length;
        3'd4:       data_out = (data_in << length) | (data_in >> (3'd4 - {1'b0, length}));
        3'd5:       data_out = (data_in >> length) | (data_in << (3'd4 - {1'b0, length}));
        3'd6: begin
          cd_rot = (cd << length) | (cd >> (3'd5 - {1'b0, length}));
          {carry_out, data_out} = cd_rot;
        end
        default: begin
          cd_rot = (cd >> length) | (cd << (3'd5 - {1'b0, length}));
          {carry_out, data_out} = cd_rot;
        end
      endcase
    end
  end
endmodule

module barrel_shift_sequencer_4_bit (
  input  logic                          clk,
  input  logic                          rst,
  barrel_shift_sequencer_4_bit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [2:0] mode_r;
  logic [3:0] rem;
  logic [3:0] work_data;
  logic       work_carry;
  logic       cmd_ready_r;
  logic       res_valid_r;
  logic [3:0] res_data_r;
  logic       res_carry_r;
  logic       busy_r;

  logic [1:0] step;
  logic [3:0] rem_next;
  logic       sh_enable;
  logic [3:0] sh_data;
  logic       sh_carry;

`ifdef SHIFT_SEQ_AMOUNT_REDUCE_EN
  // Rotates repeat with period 4 (data) or 5 ({carry,data}); shifts saturate after 4 bits.
  function automatic logic [3:0] reduce_amount(input logic [2:0] mode, input logic [3:0] amount);
    case (mode)
      3'd4, 3'd5: return {2'b00, amount[1:0]};
      3'd6, 3'd7: return amount % 4'd5;
      default:    return (amount > 4'd4) ? 4'd4 : amount;
    endcase
  endfunction
`endif

  assign step      = (rem > 4'd3) ? 2'd3 : rem[1:0];
  assign rem_next  = rem - {2'b00, step};
  assign sh_enable = (state == RUN);

  barrel_shifter_4_bit u_shifter (
    .enable    (sh_enable),
    .mode      (mode_r),
    .length    (step),
    .data_in   (work_data),
    .carry_in  (work_carry),
    .data_out  (sh_data),
    .carry_out (sh_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_r      <= 3'd0;
      rem         <= 4'd0;
      work_data   <= 4'd0;
      work_carry  <= 1'b0;
      cmd_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
      res_data_r  <= 4'd0;
      res_carry_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_tvalid) begin
            mode_r      <= bus.cmd_mode;
            work_data   <= bus.cmd_tdata;
            work_carry  <= bus.cmd_carry;
`ifdef SHIFT_SEQ_AMOUNT_REDUCE_EN
            rem         <= reduce_amount(bus.cmd_mode, bus.cmd_amount);
`else
            rem         <= bus.cmd_amount;
`endif
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          work_data  <= sh_data;
          work_carry <= sh_carry;
          rem        <= rem_next;
          if (rem_next == 4'd0) begin
            res_valid_r <= 1'b1;
            res_data_r  <= sh_data;
            res_carry_r <= (mode_r[2:1] == 2'b11) ? sh_carry : 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.res_tready) begin
            res_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_tready = cmd_ready_r;
  assign bus.res_tvalid = res_valid_r;
  assign bus.res_tdata  = res_data_r;
  assign bus.res_carry  = res_carry_r;
  assign bus.busy       = busy_r;
endmodule

// File: tb/tb_barrel_shift_sequencer_4_bit.sv
// tb/tb_barrel_shift_sequencer_4_bit.sv - directed bench for barrel_shift_sequencer_4_bit
module tb_barrel_shift_sequencer_4_bit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  barrel_shift_sequencer_4_bit_if bus ();

  barrel_shift_sequencer_4_bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] m;
    logic [3:0] a;
    logic       c;
    logic [3:0] d;
    logic [3:0] ed;
    logic       ec;
    int         p_off;
    int         p_on;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] m, input logic [3:0] a, input logic c,
                              input logic [3:0] d, input logic [3:0] ed, input logic ec,
                              input int p_off, input int p_on);
    vec_t v;
    v.m = m; v.a = a; v.c = c; v.d = d; v.ed = ed; v.ec = ec; v.p_off = p_off; v.p_on = p_on;
    return v;
  endfunction

  function automatic int pick_p(input int p_off, input int p_on);
`ifdef SHIFT_SEQ_AMOUNT_REDUCE_EN
    return p_on;
`else
    return p_off;
`endif
  endfunction

  // Drives one command, returns edges from accept until valid (bounded at 20).
  task automatic issue_cmd(input logic [2:0] m, input logic [3:0] a, input logic c,
                           input logic [3:0] d, output int cycles);
    @(negedge clk);
    bus.cmd_tvalid = 1'b1;
    bus.cmd_mode   = m;
    bus.cmd_amount = a;
    bus.cmd_carry  = c;
    bus.cmd_tdata  = d;
    @(posedge clk);
    #1;
    bus.cmd_tvalid = 1'b0;
    cycles = 0;
    while (!bus.res_tvalid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic take_result();
    bus.res_tready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.cmd_tready, bus.res_tvalid, bus.res_tdata, bus.res_carry, bus.busy} !== 8'b1_0_0000_0_0) begin
      errors++;
      $display("FAIL reset_held: got %b expected 10000000",
               {bus.cmd_tready, bus.res_tvalid, bus.res_tdata, bus.res_carry, bus.busy});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.cmd_tready, bus.res_tvalid, bus.res_tdata, bus.res_carry, bus.busy} !== 8'b1_0_0000_0_0) begin
      errors++;
      $display("FAIL reset_idle: got %b expected 10000000",
               {bus.cmd_tready, bus.res_tvalid, bus.res_tdata, bus.res_carry, bus.busy});
    end
  endtask

  task automatic test_shifts();
    vec_t q[$];
    int cyc;
    int ep;
    q.push_back(mk(3'd0, 4'd2,  1'b0, 4'b0101, 4'b0100, 1'b0, 1, 1));
    q.push_back(mk(3'd1, 4'd12, 1'b0, 4'b1100, 4'b0000, 1'b0, 4, 2));
    q.push_back(mk(3'd3, 4'd7,  1'b0, 4'b1000, 4'b1111, 1'b0, 3, 2));
    q.push_back(mk(3'd2, 4'd4,  1'b0, 4'b0111, 4'b0000, 1'b0, 2, 2));
    q.push_back(mk(3'd3, 4'd1,  1'b1, 4'b0110, 4'b0011, 1'b0, 1, 1));
    q.push_back(mk(3'd0, 4'd0,  1'b1, 4'b1111, 4'b1111, 1'b0, 1, 1));
    foreach (q[i]) begin
      ep = pick_p(q[i].p_off, q[i].p_on);
      issue_cmd(q[i].m, q[i].a, q[i].c, q[i].d, cyc);
      checks++;
      if (bus.res_tvalid !== 1'b1 || cyc != ep) begin
        errors++;
        $display("FAIL shift[%0d]_latency: got %0d cycles valid=%b expected %0d", i, cyc, bus.res_tvalid, ep);
      end
      checks++;
      if ({bus.res_carry, bus.res_tdata} !== {q[i].ec, q[i].ed}) begin
        errors++;
        $display("FAIL shift[%0d]_result: got %b expected %b", i, {bus.res_carry, bus.res_tdata}, {q[i].ec, q[i].ed});
      end
      take_result();
      checks++;
      if ({bus.cmd_tready, bus.res_tvalid, bus.busy} !== 3'b100) begin
        errors++;
        $display("FAIL shift[%0d]_handshake: got %b expected 100", i, {bus.cmd_tready, bus.res_tvalid, bus.busy});
      end
    end
  endtask

  task automatic test_rotates();
    vec_t q[$];
    int cyc;
    int ep;
    q.push_back(mk(3'd4, 4'd5,  1'b0, 4'b1001, 4'b0011, 1'b0, 2, 1));
    q.push_back(mk(3'd5, 4'd3,  1'b0, 4'b1001, 4'b0011, 1'b0, 1, 1));
    q.push_back(mk(3'd5, 4'd6,  1'b0, 4'b0001, 4'b0100, 1'b0, 2, 1));
    q.push_back(mk(3'd4, 4'd15, 1'b1, 4'b1000, 4'b0100, 1'b0, 5, 1));
    foreach (q[i]) begin
      ep = pick_p(q[i].p_off, q[i].p_on);
      issue_cmd(q[i].m, q[i].a, q[i].c, q[i].d, cyc);
      checks++;
      if (bus.res_tvalid !== 1'b1 || cyc != ep) begin
        errors++;
        $display("FAIL rot[%0d]_latency: got %0d cycles valid=%b expected %0d", i, cyc, bus.res_tvalid, ep);
      end
      checks++;
      if ({bus.res_carry, bus.res_tdata} !== {q[i].ec, q[i].ed}) begin
        errors++;
        $display("FAIL rot[%0d]_result: got %b expected %b", i, {bus.res_carry, bus.res_tdata}, {q[i].ec, q[i].ed});
      end
      take_result();
    end
  endtask

  task automatic test_carry_rotates();
    vec_t q[$];
    int cyc;
    int ep;
    q.push_back(mk(3'd7, 4'd1,  1'b0, 4'b0001, 4'b0000, 1'b1, 1, 1));
    q.push_back(mk(3'd6, 4'd15, 1'b1, 4'b1010, 4'b1010, 1'b1, 5, 1));
    q.push_back(mk(3'd6, 4'd2,  1'b0, 4'b0001, 4'b0100, 1'b0, 1, 1));
    q.push_back(mk(3'd7, 4'd7,  1'b1, 4'b0000, 4'b0100, 1'b0, 3, 1));
    q.push_back(mk(3'd6, 4'd4,  1'b1, 4'b0000, 4'b1000, 1'b0, 2, 2));
    foreach (q[i]) begin
      ep = pick_p(q[i].p_off, q[i].p_on);
      issue_cmd(q[i].m, q[i].a, q[i].c, q[i].d, cyc);
      checks++;
      if (bus.res_tvalid !== 1'b1 || cyc != ep) begin
        errors++;
        $display("FAIL rc[%0d]_latency: got %0d cycles valid=%b expected %0d", i, cyc, bus.res_tvalid, ep);
      end
      checks++;
      if ({bus.res_carry, bus.res_tdata} !== {q[i].ec, q[i].ed}) begin
        errors++;
        $display("FAIL rc[%0d]_result: got %b expected %b", i, {bus.res_carry, bus.res_tdata}, {q[i].ec, q[i].ed});
      end
      take_result();
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    issue_cmd(3'd0, 4'd1, 1'b0, 4'b0011, cyc);
    checks++;
    if (bus.res_tvalid !== 1'b1 || cyc != 1) begin
      errors++;
      $display("FAIL bp_latency: got %0d cycles valid=%b expected 1", cyc, bus.res_tvalid);
    end
    // A second command waits on the bus the whole time the result is stalled.
    bus.cmd_tvalid = 1'b1;
    bus.cmd_mode   = 3'd5;
    bus.cmd_amount = 4'd1;
    bus.cmd_carry  = 1'b0;
    bus.cmd_tdata  = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus.res_tvalid, bus.res_tdata, bus.res_carry, bus.cmd_tready, bus.busy} !== 8'b1_0110_0_0_1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %b expected 10110001", k,
                 {bus.res_tvalid, bus.res_tdata, bus.res_carry, bus.cmd_tready, bus.busy});
      end
    end
    take_result();
    checks++;
    if ({bus.cmd_tready, bus.res_tvalid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: got %b expected 10", {bus.cmd_tready, bus.res_tvalid});
    end
    issue_cmd(3'd5, 4'd1, 1'b0, 4'b0011, cyc);
    checks++;
    if (bus.res_tvalid !== 1'b1 || cyc != 1 || {bus.res_carry, bus.res_tdata} !== 5'b0_1001) begin
      errors++;
      $display("FAIL bp_second: got %0d cycles result %b expected 1 cycles 01001", cyc,
               {bus.res_carry, bus.res_tdata});
    end
    take_result();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    @(negedge clk);
    bus.cmd_tvalid = 1'b1;
    bus.cmd_mode   = 3'd1;
    bus.cmd_amount = 4'd12;
    bus.cmd_carry  = 1'b1;
    bus.cmd_tdata  = 4'b1111;
    @(posedge clk);
    #1;
    bus.cmd_tvalid = 1'b0;
    checks++;
    if ({bus.cmd_tready, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL mid_accept: got %b expected 01", {bus.cmd_tready, bus.busy});
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.cmd_tready, bus.res_tvalid, bus.res_tdata, bus.res_carry, bus.busy} !== 8'b1_0_0000_0_0) begin
      errors++;
      $display("FAIL mid_reset: got %b expected 10000000",
               {bus.cmd_tready, bus.res_tvalid, bus.res_tdata, bus.res_carry, bus.busy});
    end
    @(negedge clk);
    rst = 1'b0;
    issue_cmd(3'd1, 4'd2, 1'b0, 4'b1100, cyc);
    checks++;
    if (bus.res_tvalid !== 1'b1 || cyc != 1 || {bus.res_carry, bus.res_tdata} !== 5'b0_0011) begin
      errors++;
      $display("FAIL mid_next: got %0d cycles result %b expected 1 cycles 00011", cyc,
               {bus.res_carry, bus.res_tdata});
    end
    take_result();
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.cmd_tvalid = 1'b0;
    bus.cmd_mode   = 3'd0;
    bus.cmd_amount = 4'd0;
    bus.cmd_carry  = 1'b0;
    bus.cmd_tdata  = 4'd0;
    bus.res_tready = 1'b0;
    test_reset();
    test_shifts();
    test_rotates();
    test_carry_rotates();
    test_backpressure();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
